// File: rtl/cond_logic_mt_if.sv
// Decode-side bus of the multi-thread conditional execution unit.
// The decoder drives the master side; cond_logic_mt sits on the slave side.
interface cond_logic_mt_if #(
  parameter int NTHREAD = 2,
  parameter int TW      = (NTHREAD > 1) ? $clog2(NTHREAD) : 1
);
  // Valid marks an instruction in the decode slot. When Stall is high alongside
  // Valid, the instruction is not consumed and its side effects are suppressed,
  // so the decoder must hold it unchanged and present it again next cycle.
  logic               Valid;
  logic [TW-1:0]      Tid;
  logic [3:0]         Cond;
  logic               PCS;
  logic               RegW;
  logic               MemW;
  logic               NoWrite;
  logic [1:0]         FlagW;
  logic [3:0]         ALUFlags;
  logic               M_StartS;
  logic [1:0]         M_FlagW;
  logic               M_Done;
  logic [TW-1:0]      M_Tid;
  logic [3:0]         M_Flags;
  logic               Save;
  logic               Restore;

  logic               PCSrc;
  logic               RegWrite;
  logic               MemWrite;
  logic               M_Start;
  logic               CondEx;
  logic               Stall;
  logic [3:0]         Flags;
  logic [NTHREAD-1:0] Busy;

  modport master (
    output Valid, Tid, Cond, PCS, RegW, MemW, NoWrite, FlagW, ALUFlags,
           M_StartS, M_FlagW, M_Done, M_Tid, M_Flags, Save, Restore,
    input  PCSrc, RegWrite, MemWrite, M_Start, CondEx, Stall, Flags, Busy
  );

  modport slave (
    input  Valid, Tid, Cond, PCS, RegW, MemW, NoWrite, FlagW, ALUFlags,
           M_StartS, M_FlagW, M_Done, M_Tid, M_Flags, Save, Restore,
    output PCSrc, RegWrite, MemWrite, M_Start, CondEx, Stall, Flags, Busy
  );
endinterface

// File: rtl/cond_logic_mt.sv
// Per-thread NZCV banks with saved copies, late flag writes from multi-cycle ops,
// same-cycle forwarding of completing ops and a stall for dependent instructions.
module cond_logic_mt #(
  parameter int NTHREAD = 2,
  parameter int TW      = (NTHREAD > 1) ? $clog2(NTHREAD) : 1
) (
  input logic            CLK,
  input logic            RESET,
  cond_logic_mt_if.slave bus
);

  logic [3:0]         bank_q  [NTHREAD];
  logic [3:0]         bank_d  [NTHREAD];
  logic [3:0]         saved_q [NTHREAD];
  logic [3:0]         saved_d [NTHREAD];
  logic [1:0]         pend_q  [NTHREAD];
  logic [1:0]         pend_d  [NTHREAD];
  logic [NTHREAD-1:0] busy_q;
  logic [NTHREAD-1:0] busy_d;

  logic [TW-1:0] tid;
  logic [TW-1:0] m_tid;
  logic          tid_ok;
  logic          m_tid_ok;
  logic          commit;
  logic          fwd;
  logic          pending;
  logic          needs_flags;
  logic          cond_ex;
  logic          stall;
  logic          go;
  logic [3:0]    bank_cur;
  logic [1:0]    pend_cur;
  logic [3:0]    ef;

  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = cf;
      4'b0011: r = ~cf;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = cf & ~z;
      4'b1001: r = ~cf | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  assign tid      = bus.Tid;
  assign m_tid    = bus.M_Tid;
  // Thread ids beyond NTHREAD (non-power-of-two configs) see a zero bank and never write.
  assign tid_ok   = (32'(tid) < NTHREAD);
  assign m_tid_ok = (32'(m_tid) < NTHREAD);

  always_comb begin
    bank_cur = 4'b0000;
    pend_cur = 2'b00;
    if (tid_ok) begin
      bank_cur = bank_q[tid];
      pend_cur = pend_q[tid];
    end
  end

  // A completion only counts for a thread that actually has an op outstanding.
  assign commit = bus.M_Done & m_tid_ok & busy_q[m_tid];
  assign fwd    = commit & (m_tid == tid);

  always_comb begin
    ef = bank_cur;
    if (fwd) begin
      if (pend_cur[1]) ef[3:2] = bus.M_Flags[3:2];
      if (pend_cur[0]) ef[1:0] = bus.M_Flags[1:0];
    end
  end

  assign cond_ex = eval_cond(bus.Cond, ef);

  // An op completing this very cycle is resolved by forwarding, so it does not block.
  assign pending     = tid_ok & busy_q[tid] & ~(bus.M_Done & (m_tid == tid));
  assign needs_flags = (bus.Cond < 4'b1110) | (bus.FlagW != 2'b00) |
                       bus.M_StartS | bus.Save | bus.Restore;
  assign stall       = bus.Valid & pending & needs_flags;
  assign go          = bus.Valid & ~stall & cond_ex;

  assign bus.CondEx   = cond_ex;
  assign bus.Stall    = stall;
  assign bus.Flags    = ef;
  assign bus.Busy     = busy_q;
  assign bus.PCSrc    = go & bus.PCS;
  assign bus.RegWrite = go & bus.RegW & ~bus.NoWrite;
  assign bus.MemWrite = go & bus.MemW;
  assign bus.M_Start  = go & bus.M_StartS;

  // Later updates in this block override earlier ones on the same thread.
  always_comb begin
    bank_d  = bank_q;
    saved_d = saved_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    if (commit) begin
      if (pend_q[m_tid][1]) bank_d[m_tid][3:2] = bus.M_Flags[3:2];
      if (pend_q[m_tid][0]) bank_d[m_tid][1:0] = bus.M_Flags[1:0];
      busy_d[m_tid] = 1'b0;
    end
    if (go && tid_ok) begin
      if (bus.Save) saved_d[tid] = ef;
      if (bus.Restore) begin
        bank_d[tid] = saved_q[tid];
      end else begin
        if (bus.FlagW[1]) bank_d[tid][3:2] = bus.ALUFlags[3:2];
        if (bus.FlagW[0]) bank_d[tid][1:0] = bus.ALUFlags[1:0];
      end
      if (bus.M_StartS) begin
        busy_d[tid] = 1'b1;
        pend_d[tid] = bus.M_FlagW;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NTHREAD; i++) begin
        bank_q[i]  <= 4'b0000;
        saved_q[i] <= 4'b0000;
        pend_q[i]  <= 2'b00;
      end
      busy_q <= '0;
    end else begin
      bank_q  <= bank_d;
      saved_q <= saved_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_cond_logic_mt.sv
// Directed bench for cond_logic_mt with four threads; inputs change on the falling
// edge and outputs are sampled 1ns later, well before the next rising edge.
module tb_cond_logic_mt;

  logic CLK;
  logic RESET;
  int   n_cmp;
  int   n_fail;

  cond_logic_mt_if #(.NTHREAD(4)) bus ();

  cond_logic_mt #(.NTHREAD(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.Valid    = 1'b0;
    bus.Tid      = 2'd0;
    bus.Cond     = 4'b1110;
    bus.PCS      = 1'b0;
    bus.RegW     = 1'b0;
    bus.MemW     = 1'b0;
    bus.NoWrite  = 1'b0;
    bus.FlagW    = 2'b00;
    bus.ALUFlags = 4'b0000;
    bus.M_StartS = 1'b0;
    bus.M_FlagW  = 2'b00;
    bus.M_Done   = 1'b0;
    bus.M_Tid    = 2'd0;
    bus.M_Flags  = 4'b0000;
    bus.Save     = 1'b0;
    bus.Restore  = 1'b0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [3:0] c,
                       input logic [1:0] fw, input logic [3:0] alu);
    idle();
    bus.Valid    = 1'b1;
    bus.Tid      = t;
    bus.Cond     = c;
    bus.FlagW    = fw;
    bus.ALUFlags = alu;
  endtask

  task automatic peek(input logic [1:0] t);
    idle();
    bus.Tid = t;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    idle();
    #1;
    n_cmp++; if (bus.Busy !== 4'b0000) begin n_fail++; $display("FAIL reset_busy got %b want 0000", bus.Busy); end
    n_cmp++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.Stall); end
    n_cmp++; if (bus.Flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", bus.Flags); end
    n_cmp++; if (bus.RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite got %b want 0", bus.RegWrite); end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    peek(2'd1);
    bus.M_Done = 1'b1; bus.M_Tid = 2'd1; bus.M_Flags = 4'b1111;
    #1;
    n_cmp++; if (bus.Flags !== 4'b0000) begin n_fail++; $display("FAIL idle_done_fwd got %b want 0000", bus.Flags); end
    @(negedge CLK);
    peek(2'd1);
    #1;
    n_cmp++; if (bus.Flags !== 4'b0000) begin n_fail++; $display("FAIL idle_done_commit got %b want 0000", bus.Flags); end
  endtask

  task automatic test_basic();
    @(negedge CLK);
    issue(2'd0, 4'b0000, 2'b00, 4'b0000); bus.RegW = 1'b1;
    #1;
    n_cmp++; if (bus.CondEx !== 1'b0) begin n_fail++; $display("FAIL eq_zero_condex got %b want 0", bus.CondEx); end
    n_cmp++; if (bus.RegWrite !== 1'b0) begin n_fail++; $display("FAIL eq_zero_regwrite got %b want 0", bus.RegWrite); end
    @(negedge CLK);
    issue(2'd0, 4'b1110, 2'b11, 4'b0100); bus.RegW = 1'b1;
    #1;
    n_cmp++; if (bus.RegWrite !== 1'b1) begin n_fail++; $display("FAIL al_regwrite got %b want 1", bus.RegWrite); end
    @(negedge CLK);
    issue(2'd0, 4'b0000, 2'b00, 4'b0000); bus.RegW = 1'b1; bus.PCS = 1'b1; bus.MemW = 1'b1;
    #1;
    n_cmp++; if (bus.Flags !== 4'b0100) begin n_fail++; $display("FAIL bank0_written got %b want 0100", bus.Flags); end
    n_cmp++; if (bus.CondEx !== 1'b1) begin n_fail++; $display("FAIL eq_set_condex got %b want 1", bus.CondEx); end
    n_cmp++; if (bus.RegWrite !== 1'b1) begin n_fail++; $display("FAIL eq_set_regwrite got %b want 1", bus.RegWrite); end
    n_cmp++; if (bus.PCSrc !== 1'b1) begin n_fail++; $display("FAIL eq_set_pcsrc got %b want 1", bus.PCSrc); end
    n_cmp++; if (bus.MemWrite !== 1'b1) begin n_fail++; $display("FAIL eq_set_memwrite got %b want 1", bus.MemWrite); end
    bus.NoWrite = 1'b1;
    #1;
    n_cmp++; if (bus.RegWrite !== 1'b0) begin n_fail++; $display("FAIL nowrite_regwrite got %b want 0", bus.RegWrite); end
    n_cmp++; if (bus.MemWrite !== 1'b1) begin n_fail++; $display("FAIL nowrite_memwrite got %b want 1", bus.MemWrite); end
    bus.Valid = 1'b0;
    #1;
    n_cmp++; if (bus.CondEx !== 1'b1) begin n_fail++; $display("FAIL invalid_condex_raw got %b want 1", bus.CondEx); end
    n_cmp++; if (bus.PCSrc !== 1'b0) begin n_fail++; $display("FAIL invalid_pcsrc got %b want 0", bus.PCSrc); end
  endtask

  task automatic test_cond_table();
    logic [3:0]  flag_set [2];
    logic [15:0] exp_tab  [2];
    logic [15:0] tab;
    // Bit i of each table is the expected CondEx for Cond == i.
    flag_set[0] = 4'b1010; exp_tab[0] = 16'hE996;
    flag_set[1] = 4'b0101; exp_tab[1] = 16'hEA69;
    for (int s = 0; s < 2; s++) begin
      @(negedge CLK);
      issue(2'd3, 4'b1110, 2'b11, flag_set[s]);
      tab = exp_tab[s];
      for (int c = 0; c < 16; c++) begin
        @(negedge CLK);
        peek(2'd3);
        bus.Cond = 4'(c);
        #1;
        n_cmp++;
        if (bus.CondEx !== tab[c]) begin
          n_fail++;
          $display("FAIL cond_%0d_flags_%b got %b want %b", c, flag_set[s], bus.CondEx, tab[c]);
        end
      end
    end
  endtask

  task automatic test_isolation();
    @(negedge CLK);
    issue(2'd2, 4'b1110, 2'b11, 4'b0100);
    @(negedge CLK);
    issue(2'd1, 4'b0000, 2'b00, 4'b0000); bus.RegW = 1'b1;
    #1;
    n_cmp++; if (bus.RegWrite !== 1'b0) begin n_fail++; $display("FAIL iso_tid1_regwrite got %b want 0", bus.RegWrite); end
    @(negedge CLK);
    issue(2'd2, 4'b0000, 2'b00, 4'b0000); bus.RegW = 1'b1;
    #1;
    n_cmp++; if (bus.RegWrite !== 1'b1) begin n_fail++; $display("FAIL iso_tid2_regwrite got %b want 1", bus.RegWrite); end
    n_cmp++; if (bus.Busy !== 4'b0000) begin n_fail++; $display("FAIL iso_busy got %b want 0000", bus.Busy); end
  endtask

  task automatic test_multicycle();
    @(negedge CLK);
    issue(2'd0, 4'b1110, 2'b11, 4'b0010);
    @(negedge CLK);
    issue(2'd0, 4'b1110, 2'b00, 4'b0000); bus.M_StartS = 1'b1; bus.M_FlagW = 2'b11;
    #1;
    n_cmp++; if (bus.M_Start !== 1'b1) begin n_fail++; $display("FAIL mstart_out got %b want 1", bus.M_Start); end
    n_cmp++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL mstart_stall got %b want 0", bus.Stall); end
    @(negedge CLK);
    issue(2'd0, 4'b0000, 2'b00, 4'b0000);
    bus.RegW = 1'b1; bus.PCS = 1'b1; bus.MemW = 1'b1; bus.M_StartS = 1'b1;
    #1;
    n_cmp++; if (bus.Busy !== 4'b0001) begin n_fail++; $display("FAIL busy_tid0 got %b want 0001", bus.Busy); end
    n_cmp++; if (bus.Stall !== 1'b1) begin n_fail++; $display("FAIL dep_stall got %b want 1", bus.Stall); end
    n_cmp++; if ({bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.M_Start} !== 4'b0000) begin
      n_fail++; $display("FAIL dep_gated got %b want 0000", {bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.M_Start});
    end
    @(negedge CLK);
    issue(2'd0, 4'b1110, 2'b00, 4'b0000); bus.RegW = 1'b1;
    #1;
    n_cmp++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL indep_stall got %b want 0", bus.Stall); end
    n_cmp++; if (bus.RegWrite !== 1'b1) begin n_fail++; $display("FAIL indep_regwrite got %b want 1", bus.RegWrite); end
    bus.Save = 1'b1;
    #1;
    n_cmp++; if (bus.Stall !== 1'b1) begin n_fail++; $display("FAIL save_stall got %b want 1", bus.Stall); end
    @(negedge CLK);
    issue(2'd1, 4'b0000, 2'b00, 4'b0000);
    #1;
    n_cmp++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL other_tid_stall got %b want 0", bus.Stall); end
  endtask

  task automatic test_forward();
    @(negedge CLK);
    issue(2'd0, 4'b0000, 2'b00, 4'b0000); bus.RegW = 1'b1;
    bus.M_Done = 1'b1; bus.M_Tid = 2'd0; bus.M_Flags = 4'b0100;
    #1;
    n_cmp++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL fwd_stall got %b want 0", bus.Stall); end
    n_cmp++; if (bus.CondEx !== 1'b1) begin n_fail++; $display("FAIL fwd_condex got %b want 1", bus.CondEx); end
    n_cmp++; if (bus.Flags !== 4'b0100) begin n_fail++; $display("FAIL fwd_flags got %b want 0100", bus.Flags); end
    n_cmp++; if (bus.RegWrite !== 1'b1) begin n_fail++; $display("FAIL fwd_regwrite got %b want 1", bus.RegWrite); end
    @(negedge CLK);
    peek(2'd0);
    #1;
    n_cmp++; if (bus.Busy !== 4'b0000) begin n_fail++; $display("FAIL fwd_busy_clear got %b want 0000", bus.Busy); end
    n_cmp++; if (bus.Flags !== 4'b0100) begin n_fail++; $display("FAIL fwd_commit got %b want 0100", bus.Flags); end
  endtask

  task automatic test_ordering();
    @(negedge CLK);
    issue(2'd0, 4'b1110, 2'b00, 4'b0000); bus.M_StartS = 1'b1; bus.M_FlagW = 2'b11;
    @(negedge CLK);
    issue(2'd0, 4'b1110, 2'b01, 4'b0011);
    bus.M_Done = 1'b1; bus.M_Tid = 2'd0; bus.M_Flags = 4'b1000;
    #1;
    n_cmp++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL order_stall got %b want 0", bus.Stall); end
    n_cmp++; if (bus.Flags !== 4'b1000) begin n_fail++; $display("FAIL order_ef got %b want 1000", bus.Flags); end
    @(negedge CLK);
    peek(2'd0);
    #1;
    n_cmp++; if (bus.Flags !== 4'b1011) begin n_fail++; $display("FAIL order_bank got %b want 1011", bus.Flags); end
    // Partial mask: only NZ of the completing op lands on thread 1.
    @(negedge CLK);
    issue(2'd1, 4'b1110, 2'b00, 4'b0000); bus.M_StartS = 1'b1; bus.M_FlagW = 2'b10;
    @(negedge CLK);
    peek(2'd1);
    bus.M_Done = 1'b1; bus.M_Tid = 2'd1; bus.M_Flags = 4'b1111;
    #1;
    n_cmp++; if (bus.Flags !== 4'b1100) begin n_fail++; $display("FAIL mask_fwd got %b want 1100", bus.Flags); end
    @(negedge CLK);
    peek(2'd1);
    #1;
    n_cmp++; if (bus.Flags !== 4'b1100) begin n_fail++; $display("FAIL mask_bank got %b want 1100", bus.Flags); end
    @(negedge CLK);
    peek(2'd0);
    #1;
    n_cmp++; if (bus.Flags !== 4'b1011) begin n_fail++; $display("FAIL mask_other_tid got %b want 1011", bus.Flags); end
    @(negedge CLK);
    issue(2'd0, 4'b1110, 2'b11, 4'b0110); bus.Save = 1'b1;
    @(negedge CLK);
    peek(2'd0);
    #1;
    n_cmp++; if (bus.Flags !== 4'b0110) begin n_fail++; $display("FAIL save_flagw_bank got %b want 0110", bus.Flags); end
    @(negedge CLK);
    issue(2'd0, 4'b1110, 2'b11, 4'b0101); bus.Restore = 1'b1;
    @(negedge CLK);
    peek(2'd0);
    #1;
    n_cmp++; if (bus.Flags !== 4'b1011) begin n_fail++; $display("FAIL restore_bank got %b want 1011", bus.Flags); end
    // An op with an empty flag mask still marks the thread busy and commits nothing.
    @(negedge CLK);
    issue(2'd3, 4'b1110, 2'b00, 4'b0000); bus.M_StartS = 1'b1; bus.M_FlagW = 2'b00;
    @(negedge CLK);
    peek(2'd3);
    #1;
    n_cmp++; if (bus.Busy !== 4'b1000) begin n_fail++; $display("FAIL empty_mask_busy got %b want 1000", bus.Busy); end
    bus.M_Done = 1'b1; bus.M_Tid = 2'd3; bus.M_Flags = 4'b1010;
    @(negedge CLK);
    peek(2'd3);
    #1;
    n_cmp++; if (bus.Flags !== 4'b0101) begin n_fail++; $display("FAIL empty_mask_bank got %b want 0101", bus.Flags); end
    n_cmp++; if (bus.Busy !== 4'b0000) begin n_fail++; $display("FAIL empty_mask_clear got %b want 0000", bus.Busy); end
  endtask

  task automatic test_async_reset();
    @(negedge CLK);
    issue(2'd0, 4'b1110, 2'b00, 4'b0000); bus.M_StartS = 1'b1; bus.M_FlagW = 2'b11;
    @(negedge CLK);
    issue(2'd1, 4'b1110, 2'b00, 4'b0000); bus.M_StartS = 1'b1; bus.M_FlagW = 2'b11;
    @(negedge CLK);
    peek(2'd0);
    #1;
    n_cmp++; if (bus.Busy !== 4'b0011) begin n_fail++; $display("FAIL pre_reset_busy got %b want 0011", bus.Busy); end
    #1;
    RESET = 1'b1;
    #1;
    n_cmp++; if (bus.Busy !== 4'b0000) begin n_fail++; $display("FAIL async_reset_busy got %b want 0000", bus.Busy); end
    n_cmp++; if (bus.Flags !== 4'b0000) begin n_fail++; $display("FAIL async_reset_flags got %b want 0000", bus.Flags); end
    @(negedge CLK);
    RESET = 1'b0;
    peek(2'd0);
    bus.M_Done = 1'b1; bus.M_Tid = 2'd0; bus.M_Flags = 4'b1111;
    #1;
    n_cmp++; if (bus.Flags !== 4'b0000) begin n_fail++; $display("FAIL stale_done_fwd got %b want 0000", bus.Flags); end
    @(negedge CLK);
    peek(2'd0);
    #1;
    n_cmp++; if (bus.Flags !== 4'b0000) begin n_fail++; $display("FAIL stale_done_bank got %b want 0000", bus.Flags); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_cond_table();
    test_isolation();
    test_multicycle();
    test_forward();
    test_ordering();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_logic_mt.md
Name: cond_logic_mt

Overview:
- Multi-thread, multi-cycle-aware successor to the single-bank conditional execution unit.
- Holds one NZCV flag bank and one saved-flags register per hardware thread, and evaluates the ARM condition field against the issuing thread's bank.
- Tracks one outstanding multi-cycle operation per thread whose flag write retires late, and stalls dependent instructions until that write lands.
- Forwards flags from a completing multi-cycle op in the same cycle. Sits between decode and execute/writeback.

Parameters:
- NTHREAD, 2, number of hardware threads / flag banks (>=1)
- TW, $clog2(NTHREAD) (min 1), thread-id width

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- Valid  in  1  instruction present this cycle
- Tid  in  TW  issuing thread
- Cond  in  4  condition field
- PCS, RegW, MemW, NoWrite  in  1 each  decoded controls
- FlagW  in  2  [1]=update NZ, [0]=update CV
- ALUFlags  in  4  {N,Z,C,V} from ALU
- M_StartS  in  1  instruction launches a multi-cycle op
- M_FlagW  in  2  flag-write mask the multi-cycle op will apply on completion
- M_Done  in  1  multi-cycle op completes
- M_Tid  in  TW  thread of completing op
- M_Flags  in  4  {N,Z,C,V} of completing op
- Save  in  1  copy the thread's flags to its saved register
- Restore  in  1  load the thread's flags from its saved register
- PCSrc, RegWrite, MemWrite, M_Start  out  1 each  gated controls
- CondEx  out  1  condition passed (raw, before Valid/Stall gating)
- Stall  out  1  hold issuing instruction
- Flags  out  4  effective (forwarded) NZCV of Tid
- Busy  out  NTHREAD  per-thread multi-cycle op outstanding

Behaviour:
- Reset (asynchronous): all flag banks, saved registers, Busy and pending masks go to 0.
  - Combinational outputs then follow from the zero state: Stall=0; gated outputs=0 unless Valid.
  - Reset mid-operation abandons outstanding ops; a later M_Done for them is ignored.
- Effective flags EF = bank[Tid], except when M_Done & Busy[M_Tid] & M_Tid==Tid:
  - NZ are replaced by M_Flags[3:2] if pendmask[Tid][1].
  - CV are replaced by M_Flags[1:0] if pendmask[Tid][0].
  - Flags = EF.
- CondEx from EF:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110/1111 always 1
- Hazard. Let P = Busy[Tid] & ~(M_Done & M_Tid==Tid). Stall = Valid & P & (Cond<1110 | FlagW!=0 | M_StartS | Save | Restore).
- Go = Valid & ~Stall & CondEx.
- Gated outputs:
  - PCSrc = Go&PCS
  - RegWrite = Go&RegW&~NoWrite
  - MemWrite = Go&MemW
  - M_Start = Go&M_StartS
- Sequential updates, applied in this order within one clock edge (later overrides earlier):
  1. If M_Done & Busy[M_Tid]: commit masked M_Flags to bank[M_Tid] and clear Busy[M_Tid]. If the thread is not busy, M_Done is ignored.
  2. If Go & Save: saved[Tid] <= EF (pre-update value).
  3. If Go & Restore: bank[Tid] <= saved[Tid]; FlagW is ignored in that cycle.
  4. Else if Go: FlagW[1] sets NZ <= ALUFlags[3:2]; FlagW[0] sets CV <= ALUFlags[1:0].
  5. If Go & M_StartS: Busy[Tid] <= 1 and pendmask[Tid] <= M_FlagW. An op with M_FlagW=00 still sets Busy.
- Threads are independent: a stall or completion on one thread never affects another's bank.
- No internal latency: all outputs are combinational from the registered state plus the current inputs.

Test Plan:
- Reset, then Valid, Tid=0, Cond=0000 (EQ), RegW=1 -> CondEx=0, RegWrite=0. Same instruction with FlagW=11, ALUFlags=0100, Cond=1110 -> next cycle bank0=0100; an EQ instruction now gives RegWrite=1.
- Thread isolation, NTHREAD=4: write Z=1 on Tid=2 -> an EQ instruction on Tid=1 fails and on Tid=2 passes; Busy stays 0000.
- Multi-cycle op on Tid=0 with M_StartS=1, M_FlagW=11 -> M_Start=1, Busy=0001. Next cycle a Cond=0000 instruction on Tid 0 -> Stall=1 and all gated outputs 0. The same instruction with Cond=1110, FlagW=00 -> no stall. Tid=1 with Cond=0000 -> no stall.
- Forwarding: Busy[0]=1 and M_Done=1, M_Tid=0, M_Flags=0100 in the same cycle as an EQ instruction on Tid 0 -> Stall=0, CondEx=1, Flags=0100. Next cycle Busy[0]=0 and bank0=0100.
- Ordering: M_Done commits NZCV=1000 while a non-stalled instruction on the same thread has FlagW=01, ALUFlags=0011 -> bank=1011. Save with Cond=1110 stores the EF value, and a later Restore overrides a simultaneous FlagW.
- Reset asserted while Busy=0011 -> Busy=0000 immediately, asynchronously. A later M_Done for Tid 0 -> no flag change.
